// File: rtl/anabellek_getir_yanitlayici.sv
// rtl/anabellek_getir_yanitlayici.sv - block-read responder between the fetch stage and a word-wide RAM
// Optional feature macro: ANABELLEK_SON_OBEK_EN (one-entry last-block buffer).
module anabellek_getir_yanitlayici #(
  parameter int KELIME_SAYISI = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       getir_asamasi_istek_i,
  input  logic [31:0]                getir_adres_i,
  input  logic                       getir_oku_i,
  input  logic                       getir_iptal_i,
  output logic                       anabellek_musait_o,
  output logic                       getir_asamasina_veri_hazir_o,
  output logic [32*KELIME_SAYISI-1:0] okunan_obek_o,
  output logic                       ram_istek_o,
  output logic [31:0]                ram_adres_o,
  input  logic                       ram_gecerli_i,
  input  logic [31:0]                ram_veri_i
);

  localparam int KW = $clog2(KELIME_SAYISI);
  localparam logic [31:0] OFS_MASKE = 32'(4 * KELIME_SAYISI - 1);

  typedef enum logic [1:0] {BOSTA, OKU, HAZIR} durum_t;

  durum_t                      durum_q, durum_d;
  logic [KW-1:0]               k_q, k_d;
  logic [31:0]                 taban_q, taban_d;
  logic [32*KELIME_SAYISI-1:0] obek_q, obek_d;

  logic        istek_kabul;
  logic [31:0] istek_taban;
  logic        son_kelime;

  assign istek_kabul = getir_asamasi_istek_i & getir_oku_i & ~getir_iptal_i;
  assign istek_taban = getir_adres_i & ~OFS_MASKE;
  assign son_kelime  = (k_q == KW'(KELIME_SAYISI - 1));

`ifdef ANABELLEK_SON_OBEK_EN
  logic                        son_gecerli_q;
  logic [31:0]                 son_etiket_q;
  logic [32*KELIME_SAYISI-1:0] son_veri_q;
  logic                        son_isabet;

  assign son_isabet = son_gecerli_q && (son_etiket_q == istek_taban);

  // HAZIR is only reached with a complete, unflushed block, so it is always safe to store.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      son_gecerli_q <= 1'b0;
      son_etiket_q  <= '0;
      son_veri_q    <= '0;
    end else if (durum_q == HAZIR) begin
      son_gecerli_q <= 1'b1;
      son_etiket_q  <= taban_q;
      son_veri_q    <= obek_q;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q <= BOSTA;
      k_q     <= '0;
      taban_q <= '0;
      obek_q  <= '0;
    end else begin
      durum_q <= durum_d;
      k_q     <= k_d;
      taban_q <= taban_d;
      obek_q  <= obek_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    k_d     = k_q;
    taban_d = taban_q;
    obek_d  = obek_q;
    case (durum_q)
      BOSTA: begin
        if (istek_kabul) begin
          taban_d = istek_taban;
          k_d     = '0;
`ifdef ANABELLEK_SON_OBEK_EN
          if (son_isabet) begin
            durum_d = HAZIR;
            obek_d  = son_veri_q;
          end else begin
            durum_d = OKU;
          end
`else
          durum_d = OKU;
`endif
        end
      end
      OKU: begin
        if (ram_gecerli_i) begin
          for (int i = 0; i < KELIME_SAYISI; i++) begin
            if (k_q == KW'(i)) obek_d[32*i +: 32] = ram_veri_i;
          end
          k_d = k_q + KW'(1);
          // A flush still keeps the word that arrived with it, but never reaches HAZIR.
          if (getir_iptal_i)   durum_d = BOSTA;
          else if (son_kelime) durum_d = HAZIR;
        end else if (getir_iptal_i) begin
          durum_d = BOSTA;
        end
      end
      HAZIR:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  assign anabellek_musait_o           = (durum_q == BOSTA);
  assign getir_asamasina_veri_hazir_o = (durum_q == HAZIR);
  assign ram_istek_o                  = (durum_q == OKU);
  assign ram_adres_o                  = (durum_q == OKU) ? (taban_q + {{(30-KW){1'b0}}, k_q, 2'b00}) : 32'h0;
  assign okunan_obek_o                = obek_q;

endmodule

// File: tb/tb_anabellek_getir_yanitlayici.sv
// tb/tb_anabellek_getir_yanitlayici.sv - self-checking bench with a RAM responder and block-level reference model
module tb_anabellek_getir_yanitlayici;

  localparam int K = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           getir_asamasi_istek_i;
  logic [31:0]    getir_adres_i;
  logic           getir_oku_i;
  logic           getir_iptal_i;
  logic           anabellek_musait_o;
  logic           getir_asamasina_veri_hazir_o;
  logic [32*K-1:0] okunan_obek_o;
  logic           ram_istek_o;
  logic [31:0]    ram_adres_o;
  logic           ram_gecerli_i;
  logic [31:0]    ram_veri_i;

  anabellek_getir_yanitlayici #(.KELIME_SAYISI(K)) dut (
    .clk_i                        (clk_i),
    .rst_i                        (rst_i),
    .getir_asamasi_istek_i        (getir_asamasi_istek_i),
    .getir_adres_i                (getir_adres_i),
    .getir_oku_i                  (getir_oku_i),
    .getir_iptal_i                (getir_iptal_i),
    .anabellek_musait_o           (anabellek_musait_o),
    .getir_asamasina_veri_hazir_o (getir_asamasina_veri_hazir_o),
    .okunan_obek_o                (okunan_obek_o),
    .ram_istek_o                  (ram_istek_o),
    .ram_adres_o                  (ram_adres_o),
    .ram_gecerli_i                (ram_gecerli_i),
    .ram_veri_i                   (ram_veri_i)
  );

  always #5 clk_i = ~clk_i;

  int kontrol_sayisi = 0;
  int hata_sayisi = 0;
  logic [31:0] tohum = 32'h0;
  int bekleme_g = 0;
  logic son_gecerli = 1'b0;
  logic [31:0] son_taban = 32'h0;

  // Monitor-owned counters
  int nabiz_sayisi = 0;
  int istek_yukselen = 0;
  logic istek_onceki = 1'b0;

  // Responder-owned state
  logic [31:0] adres_log[$];
  int kararsiz = 0;
  int sayac = 0;
  logic [31:0] bekleme_adres = 32'h0;

  function automatic logic [31:0] mem_oku(input logic [31:0] a);
    case (a)
      32'h1030: return 32'h11;
      32'h1034: return 32'h22;
      32'h1038: return 32'h33;
      32'h103C: return 32'h44;
      default:  return {a[15:0], a[31:16]} ^ tohum;
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (getir_asamasina_veri_hazir_o) nabiz_sayisi <= nabiz_sayisi + 1;
    if (ram_istek_o && !istek_onceki) istek_yukselen <= istek_yukselen + 1;
    istek_onceki <= ram_istek_o;
  end

  // RAM model: answers each word after bekleme_g wait cycles
  initial begin
    ram_gecerli_i = 1'b0;
    ram_veri_i = 32'h0;
    forever begin
      @(negedge clk_i);
      if (ram_istek_o && rst_i) begin
        if (sayac == 0) bekleme_adres = ram_adres_o;
        else if (ram_adres_o !== bekleme_adres) kararsiz++;
        if (sayac >= bekleme_g) begin
          ram_gecerli_i = 1'b1;
          ram_veri_i = mem_oku(ram_adres_o);
          adres_log.push_back(ram_adres_o);
          sayac = 0;
        end else begin
          ram_gecerli_i = 1'b0;
          ram_veri_i = 32'hDEAD_BEEF;
          sayac++;
        end
      end else begin
        ram_gecerli_i = 1'b0;
        sayac = 0;
      end
    end
  end

  task automatic kontrol(input string ad, input logic [255:0] gozlenen, input logic [255:0] beklenen);
    kontrol_sayisi++;
    assert (gozlenen === beklenen) else begin
      hata_sayisi++;
      $error("FAIL %s gozlenen=%0h beklenen=%0h", ad, gozlenen, beklenen);
    end
  endtask

  task automatic istek_ver(input logic [31:0] adres, input logic oku);
    int n;
    n = 0;
    while (!anabellek_musait_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    kontrol("musait bekleme", 256'(n < 100), 256'(1));
    getir_asamasi_istek_i = 1'b1;
    getir_adres_i = adres;
    getir_oku_i = oku;
    @(negedge clk_i);
    getir_asamasi_istek_i = 1'b0;
    getir_oku_i = 1'b0;
  endtask

  task automatic blok_oku(input logic [31:0] adres, input int bekleme, input string ad);
    logic [31:0] taban;
    logic [255:0] beklenen;
    logic isabet;
    int beklenen_gecikme, gecikme, nabiz_once, istek_once;
    taban = adres & ~32'(4*K - 1);
    beklenen = '0;
    for (int k = 0; k < K; k++) beklenen[32*k +: 32] = mem_oku(taban + 32'(4*k));
`ifdef ANABELLEK_SON_OBEK_EN
    isabet = son_gecerli && (son_taban == taban);
`else
    isabet = 1'b0;
`endif
    beklenen_gecikme = isabet ? 1 : 1 + K * (bekleme + 1);
    bekleme_g = bekleme;
    @(negedge clk_i);
    nabiz_once = nabiz_sayisi;
    istek_once = istek_yukselen;
    istek_ver(adres, 1'b1);
    gecikme = 1;
    while (!getir_asamasina_veri_hazir_o && gecikme < 200) begin
      @(negedge clk_i);
      gecikme++;
    end
    kontrol({ad, " gecikme"}, 256'(gecikme), 256'(beklenen_gecikme));
    kontrol({ad, " veri"}, 256'(okunan_obek_o), beklenen);
    @(negedge clk_i);
    kontrol({ad, " tek nabiz"}, 256'(getir_asamasina_veri_hazir_o), 256'(0));
    kontrol({ad, " musait"}, 256'(anabellek_musait_o), 256'(1));
    kontrol({ad, " veri tutuldu"}, 256'(okunan_obek_o), beklenen);
    @(negedge clk_i);
    kontrol({ad, " nabiz sayisi"}, 256'(nabiz_sayisi - nabiz_once), 256'(1));
    kontrol({ad, " ram istek sayisi"}, 256'(istek_yukselen - istek_once), 256'(isabet ? 0 : 1));
    son_gecerli = 1'b1;
    son_taban = taban;
  endtask

  initial begin
    int nabiz_once, istek_once;
    logic [31:0] rastgele_adres;
    tohum = $urandom;
    rst_i = 1'b0;
    getir_asamasi_istek_i = 1'b0;
    getir_adres_i = 32'h0;
    getir_oku_i = 1'b0;
    getir_iptal_i = 1'b0;
    repeat (3) @(negedge clk_i);
    kontrol("reset musait", 256'(anabellek_musait_o), 256'(1));
    kontrol("reset hazir", 256'(getir_asamasina_veri_hazir_o), 256'(0));
    kontrol("reset ram_istek", 256'(ram_istek_o), 256'(0));
    kontrol("reset ram_adres", 256'(ram_adres_o), 256'(0));
    kontrol("reset obek", 256'(okunan_obek_o), 256'(0));
    rst_i = 1'b1;
    @(negedge clk_i);

    // Reset after word 1 has been captured
    bekleme_g = 0;
    istek_ver(32'h6000, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    nabiz_once = nabiz_sayisi;
    rst_i = 1'b0;
    #1;
    kontrol("okuda reset musait", 256'(anabellek_musait_o), 256'(1));
    kontrol("okuda reset ram_istek", 256'(ram_istek_o), 256'(0));
    kontrol("okuda reset obek", 256'(okunan_obek_o), 256'(0));
    kontrol("okuda reset hazir", 256'(getir_asamasina_veri_hazir_o), 256'(0));
    @(negedge clk_i);
    rst_i = 1'b1;
    son_gecerli = 1'b0;
    repeat (8) @(negedge clk_i);
    kontrol("okuda reset nabiz yok", 256'(nabiz_sayisi), 256'(nabiz_once));

    // Zero-wait read and its word address sequence
    blok_oku(32'h0000_1038, 0, "sifir bekleme");
    kontrol("sifir bekleme log boyu", 256'(adres_log.size() >= 4), 256'(1));
    if (adres_log.size() >= 4)
      for (int i = 0; i < 4; i++)
        kontrol("sifir bekleme ram_adres", 256'(adres_log[adres_log.size() - 4 + i]), 256'(32'h1030 + 32'(4*i)));
    kontrol("sifir bekleme obek sabit", 256'(okunan_obek_o), 256'(128'h00000044_00000033_00000022_00000011));

`ifdef ANABELLEK_SON_OBEK_EN
    blok_oku(32'h0000_1038, 0, "tampon isabet");
    blok_oku(32'h0000_1040, 0, "tampon iska");
`endif

    // Two wait cycles per word
    blok_oku(32'h0000_4004, 2, "bekleme");
    kontrol("bekleme adres kararli", 256'(kararsiz), 256'(0));

    // Flush with the third word arriving in the same cycle
    bekleme_g = 0;
    @(negedge clk_i);
    nabiz_once = nabiz_sayisi;
    istek_ver(32'h7000, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    getir_iptal_i = 1'b1;
    @(negedge clk_i);
    getir_iptal_i = 1'b0;
    kontrol("iptal musait", 256'(anabellek_musait_o), 256'(1));
    kontrol("iptal ram_istek", 256'(ram_istek_o), 256'(0));
    repeat (6) @(negedge clk_i);
    kontrol("iptal nabiz yok", 256'(nabiz_sayisi), 256'(nabiz_once));
    blok_oku(32'h0000_2000, 0, "iptal sonrasi");

    // Requests while busy are ignored
    bekleme_g = 1;
    @(negedge clk_i);
    nabiz_once = nabiz_sayisi;
    istek_once = istek_yukselen;
    istek_ver(32'h3000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      getir_asamasi_istek_i = i[0];
      getir_oku_i = 1'b1;
      getir_adres_i = 32'h5000;
      @(negedge clk_i);
    end
    getir_asamasi_istek_i = 1'b0;
    getir_oku_i = 1'b0;
    repeat (12) @(negedge clk_i);
    kontrol("mesgul nabiz", 256'(nabiz_sayisi - nabiz_once), 256'(1));
    kontrol("mesgul ram istek", 256'(istek_yukselen - istek_once), 256'(1));
    kontrol("mesgul veri", 256'(okunan_obek_o[31:0]), 256'(mem_oku(32'h3000)));
    son_gecerli = 1'b1;
    son_taban = 32'h3000;

    // Request without read qualifier
    istek_once = istek_yukselen;
    getir_asamasi_istek_i = 1'b1;
    getir_oku_i = 1'b0;
    getir_adres_i = 32'h8000;
    repeat (3) begin
      @(negedge clk_i);
      kontrol("oku=0 musait", 256'(anabellek_musait_o), 256'(1));
    end
    getir_asamasi_istek_i = 1'b0;
    @(negedge clk_i);
    kontrol("oku=0 ram istek yok", 256'(istek_yukselen), 256'(istek_once));

    // Randomized reads against the reference model
    for (int t = 0; t < 6; t++) begin
      rastgele_adres = $urandom;
      blok_oku(rastgele_adres, int'($urandom_range(0, 3)), "rastgele");
    end

    $display("CHECKS %0d ERRORS %0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL zaman asimi");
    $fatal(1, "zaman asimi");
  end

endmodule

// File: doc/anabellek_getir_yanitlayici.md
# anabellek_getir_yanitlayici

Main-memory-side responder for the fetch-stage block-read protocol. It accepts a block request from the instruction cache controller and reads the aligned block from a word-wide RAM port, one word at a time. It then returns the full block with a one-cycle ready pulse. It sits between the fetch stage's memory request outputs and the main memory RAM port.

## Interface
Parameters:
- KELIME_SAYISI, 4, 32-bit words per block; legal values 2, 4, 8; block width is 32*KELIME_SAYISI.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- getir_asamasi_istek_i  input  1  request valid from the fetch stage.
- getir_adres_i  input  32  request address; low log2(4*KELIME_SAYISI) bits ignored.
- getir_oku_i  input  1  read qualifier; a request is accepted only with this high.
- getir_iptal_i  input  1  flush from branch misprediction, jal or mret redirect.
- anabellek_musait_o  output  1  responder idle and able to accept a request.
- getir_asamasina_veri_hazir_o  output  1  one-cycle pulse: okunan_obek_o is valid.
- okunan_obek_o  output  32*KELIME_SAYISI  returned block; word k at bits [32k+31:32k].
- ram_istek_o  output  1  word read request to RAM.
- ram_adres_o  output  32  word address, byte-addressed and 4-aligned.
- ram_gecerli_i  input  1  RAM read data valid; completes the current word.
- ram_veri_i  input  32  RAM read data.

## Operation
State machine:
- States are BOSTA, OKU and HAZIR; reset enters BOSTA.
- BOSTA → OKU on getir_asamasi_istek_i & getir_oku_i & !getir_iptal_i.
  - Latches the base address (getir_adres_i with offset bits zeroed).
  - Clears word counter k.
- OKU:
  - ram_istek_o = 1, ram_adres_o = base + 4k.
  - On ram_gecerli_i, ram_veri_i is written into word k and k increments.
  - After word KELIME_SAYISI-1 is captured, the next state is HAZIR.
  - ram_istek_o drops in the cycle after the last capture.
- HAZIR: getir_asamasina_veri_hazir_o = 1 for exactly one cycle, then → BOSTA.
- anabellek_musait_o = (state == BOSTA).
- A request presented while not in BOSTA is ignored. The requester holds it until musait is seen.
- okunan_obek_o is written only during OKU captures. It holds its value after HAZIR.
- Request with getir_oku_i = 0: ignored, stays in BOSTA; the write path is not supported.

Flush (getir_iptal_i):
- In OKU with no ram_gecerli_i this cycle: ram_istek_o deasserts next cycle; → BOSTA, no ready pulse.
- In OKU with ram_gecerli_i in the same cycle: the word is captured, then → BOSTA, no ready pulse.
- In HAZIR: the pulse is still issued; the fetch side discards it.

Other rules:
- Address arithmetic is 32-bit. base + 4k never carries into the offset-bit boundary because of alignment.
- rst_i low at any time: immediate BOSTA, k = 0, all outputs at their reset values. A RAM word in flight is abandoned.

## Timing
Reset values:
- anabellek_musait_o = 1.
- getir_asamasina_veri_hazir_o = 0, ram_istek_o = 0.
- ram_adres_o = 0, okunan_obek_o = 0.

Latency:
- Request is sampled at edge E0.
- With zero-wait RAM (ram_gecerli_i high in the first cycle of each request), words are captured at E1..E4 and the ready pulse is high during the cycle after E4.
- Miss latency is 5 cycles, plus the total RAM wait cycles.

Rules:
- Back-to-back requests: musait returns high in the cycle after HAZIR, so there is at least 1 idle cycle between ready pulses.
- No combinational path from getir_* inputs to ram_* outputs; all ram_* outputs are registered or decoded from state.

## Configuration
- Macro: ANABELLEK_SON_OBEK_EN.
- Defined: adds a one-entry last-block buffer (valid bit, base-address tag, block data).
  - A completed block (not flushed) is stored on entry to HAZIR.
  - Request in BOSTA with matching base and valid: BOSTA → HAZIR directly, no RAM access, okunan_obek_o loaded from the buffer. The ready pulse comes 1 cycle after E0.
  - The valid bit is cleared only by reset; instruction memory is read-only.
- Undefined: every request goes through OKU. There is no buffer logic.

## Test plan
- Reset mid-OKU: drop rst_i after word 1.
  - Required: musait = 1, ram_istek_o = 0, okunan_obek_o = 0 immediately.
  - No ready pulse.
- Zero-wait read: request adres 0x0000_1038, RAM returns 0x11,0x22,0x33,0x44.
  - Required: ram_adres_o = 0x1030, 0x1034, 0x1038, 0x103C.
  - Ready pulse 5 cycles after E0; okunan_obek_o = 0x00000044_00000033_00000022_00000011.
- Wait states: 2-cycle RAM delay per word.
  - Required: ram_istek_o/ram_adres_o stable while waiting; ready at cycle 13.
  - Exactly one pulse.
- Flush mid-block: getir_iptal_i after word 2 captured.
  - Required: no ready pulse, musait = 1 the next cycle.
  - A new request to 0x2000 completes normally with correct data.
- Busy/ignored requests: toggle istek during OKU; present istek with oku = 0 in BOSTA.
  - Required: neither is accepted and no extra RAM requests are issued.
- ANABELLEK_SON_OBEK_EN: repeat the request to 0x1038, then request 0x1040.
  - Required: the first gives ready 1 cycle after E0 with the same block and ram_istek_o never high.
  - The second performs a full RAM read.
